// File: rtl/pkt_src_framer.sv
// Packet source framer: buffers payload bytes, then on send emits header, payload
// and XOR parity as a valid/ready byte stream that tolerates downstream backpressure.
module pkt_src_framer #(
  parameter int DATA_W      = 8,
  parameter int MAX_PAYLOAD = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_full,
  input  logic              send,
  input  logic [1:0]        send_dest,
  output logic              busy,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sop,
  output logic              out_eop,
  input  logic              out_ready,
  output logic              send_err
);

  localparam int         AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [5:0] MAX_CNT = 6'(MAX_PAYLOAD);

  typedef enum logic [1:0] {IDLE, HDR, PAY, PAR} state_t;

  state_t            state;
  logic [5:0]        cnt;
  logic [5:0]        rd;
  logic [DATA_W-1:0] par;
  logic [DATA_W-1:0] mem [0:(1<<AW)-1];

  logic              wr_ok;
  logic              accept;
  logic [5:0]        cnt_wr;
  logic [5:0]        rd_nxt;
  logic [DATA_W-1:0] hdr;

  assign wr_ok  = (state == IDLE) && wr_en && !wr_full;
  assign accept = out_valid && out_ready;
  // A write in the same cycle as send is counted in the header length.
  assign cnt_wr = wr_ok ? cnt + 6'd1 : cnt;
  assign rd_nxt = rd + 6'd1;
  assign hdr    = DATA_W'({send_dest, cnt_wr});

  // Payload storage carries no reset; cnt alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[cnt[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rd        <= '0;
      par       <= '0;
      wr_full   <= 1'b0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      send_err  <= 1'b0;
    end else begin
      send_err <= send && (state != IDLE);
      case (state)
        IDLE: begin
          cnt     <= cnt_wr;
          wr_full <= (cnt_wr == MAX_CNT);
          if (send) begin
            if (cnt_wr != 6'd0) begin
              state     <= HDR;
              rd        <= '0;
              busy      <= 1'b1;
              wr_full   <= 1'b1;
              out_valid <= 1'b1;
              out_sop   <= 1'b1;
              out_data  <= hdr;
            end else begin
              send_err <= 1'b1;
            end
          end
        end
        HDR: begin
          if (accept) begin
            state    <= PAY;
            par      <= out_data;
            out_sop  <= 1'b0;
            out_data <= mem[AW'(0)];
          end
        end
        PAY: begin
          if (accept) begin
            par <= par ^ out_data;
            rd  <= rd_nxt;
            // Parity byte folds in the last payload byte as it leaves.
            if (rd == cnt - 6'd1) begin
              state    <= PAR;
              out_eop  <= 1'b1;
              out_data <= par ^ out_data;
            end else begin
              out_data <= mem[rd_nxt[AW-1:0]];
            end
          end
        end
        PAR: begin
          if (accept) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            wr_full   <= 1'b0;
            out_valid <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
